// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: sequenced ALU controller for the MIPS datapath.
// Decodes ALUOp/funct into the 4-bit ALU control code and executes the shift
// family (sll/srl/sra/sllv/srlv/srav) behind a valid/ready handshake.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   valid_i / ready_o    request handshake (accept = valid_i && ready_o)
//   ALUOp_i, funct_i     operation class / R-type funct field
//   shamt_i, rs_i, rt_i  immediate amount, variable amount source, value to shift
//   ALUCtrl_o            ALU control code (1111 for shifts)
//   shift_res_o          shifter result
//   sel_shift_o          result mux picks shift_res_o
//   illegal_o            undefined ALUOp/funct combination
//   valid_o              one-cycle completion pulse
//
// Build option: ALU_CTRL_BARREL_EN selects a single-cycle barrel shifter and
// drops the SHIFT state; otherwise shifts run 1 bit per cycle.
module alu_ctrl_seq #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [2:0]         ALUOp_i,
  input  logic [5:0]         funct_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [DATA_W-1:0]  rs_i,
  input  logic [DATA_W-1:0]  rt_i,
  output logic [3:0]         ALUCtrl_o,
  output logic [DATA_W-1:0]  shift_res_o,
  output logic               sel_shift_o,
  output logic               illegal_o,
  output logic               valid_o
);

  localparam logic [1:0] IDLE  = 2'd0;
`ifndef ALU_CTRL_BARREL_EN
  localparam logic [1:0] SHIFT = 2'd1;
`endif
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]         state;
  logic [3:0]         dec_ctrl;
  logic               dec_ill;
  logic               dec_shift;
  logic [SHAMT_W-1:0] dec_amt;

  // Only the low SHAMT_W bits of rs_i carry the shift amount.
  logic unused_rs_hi;
  assign unused_rs_hi = ^rs_i[DATA_W-1:SHAMT_W];

  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);

  // funct[2] marks the variable-amount forms (sllv/srlv/srav).
  assign dec_amt = funct_i[2] ? rs_i[SHAMT_W-1:0] : shamt_i;

  always_comb begin
    dec_ctrl  = 4'b0000;
    dec_ill   = 1'b0;
    dec_shift = 1'b0;
    case (ALUOp_i)
      3'b000:  dec_ctrl = 4'b0010;
      3'b001:  dec_ctrl = 4'b0110;
      3'b100:  dec_ctrl = 4'b0010;
      3'b101:  dec_ctrl = 4'b0111;
      3'b110:  dec_ctrl = 4'b0001;
      3'b111:  dec_ctrl = 4'b0010;
      3'b011:  dec_ill  = 1'b1;
      default: begin
        case (funct_i)
          6'h20: dec_ctrl = 4'b0010;
          6'h22: dec_ctrl = 4'b0110;
          6'h24: dec_ctrl = 4'b0000;
          6'h25: dec_ctrl = 4'b0001;
          6'h2a: dec_ctrl = 4'b0111;
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
            dec_ctrl  = 4'b1111;
            dec_shift = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
    endcase
  end

`ifdef ALU_CTRL_BARREL_EN
  // funct[1:0]: 00 left, 10 logical right, 11 arithmetic right.
  logic [DATA_W-1:0] barrel_res;
  always_comb begin
    case (funct_i[1:0])
      2'b10:   barrel_res = rt_i >> dec_amt;
      2'b11:   barrel_res = $unsigned($signed(rt_i) >>> dec_amt);
      default: barrel_res = rt_i << dec_amt;
    endcase
  end
`else
  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] cnt;
  logic [DATA_W-1:0]  sreg;

  function automatic logic [DATA_W-1:0] shift1(input logic [DATA_W-1:0] v,
                                               input logic [1:0] op);
    case (op)
      2'b10:   shift1 = {1'b0, v[DATA_W-1:1]};
      2'b11:   shift1 = {v[DATA_W-1], v[DATA_W-1:1]};
      default: shift1 = {v[DATA_W-2:0], 1'b0};
    endcase
  endfunction
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ALUCtrl_o   <= '0;
      shift_res_o <= '0;
      sel_shift_o <= 1'b0;
      illegal_o   <= 1'b0;
`ifndef ALU_CTRL_BARREL_EN
      op_q        <= '0;
      cnt         <= '0;
      sreg        <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (valid_i) begin
`ifdef ALU_CTRL_BARREL_EN
          state       <= DONE;
          ALUCtrl_o   <= dec_ctrl;
          illegal_o   <= dec_ill;
          sel_shift_o <= dec_shift;
          if (dec_shift) shift_res_o <= barrel_res;
`else
          if (dec_shift) begin
            sreg <= rt_i;
            cnt  <= dec_amt;
            op_q <= funct_i[1:0];
          end
          if (dec_shift && dec_amt != '0) begin
            state <= SHIFT;
          end else begin
            // Non-shift or zero-amount shift completes immediately.
            state       <= DONE;
            ALUCtrl_o   <= dec_ctrl;
            illegal_o   <= dec_ill;
            sel_shift_o <= dec_shift;
            if (dec_shift) shift_res_o <= rt_i;
          end
`endif
        end
`ifndef ALU_CTRL_BARREL_EN
        SHIFT: begin
          sreg <= shift1(sreg, op_q);
          cnt  <= cnt - SHAMT_W'(1);
          // Outputs only move at completion, so the final step writes them.
          if (cnt == SHAMT_W'(1)) begin
            state       <= DONE;
            shift_res_o <= shift1(sreg, op_q);
            ALUCtrl_o   <= 4'b1111;
            sel_shift_o <= 1'b1;
            illegal_o   <= 1'b0;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: randomized + directed bench for alu_ctrl_seq against a
// behavioural model of the decode table, shift arithmetic and latency.
module tb_alu_ctrl_seq;
  logic        clk = 1'b0;
  logic        rst_i, valid_i;
  logic        ready_o, sel_shift_o, illegal_o, valid_o;
  logic [2:0]  ALUOp_i;
  logic [5:0]  funct_i;
  logic [4:0]  shamt_i;
  logic [31:0] rs_i, rt_i, shift_res_o;
  logic [3:0]  ALUCtrl_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] fn_tab [13] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02,
                              6'h03, 6'h04, 6'h06, 6'h07, 6'h18, 6'h01};

  alu_ctrl_seq #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .ALUOp_i(ALUOp_i), .funct_i(funct_i), .shamt_i(shamt_i), .rs_i(rs_i),
    .rt_i(rt_i), .ALUCtrl_o(ALUCtrl_o), .shift_res_o(shift_res_o),
    .sel_shift_o(sel_shift_o), .illegal_o(illegal_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  // Reference: decode table, shift by plain arithmetic, latency in cycles after accept.
  function automatic void model(input logic [2:0] op, input logic [5:0] fn,
                                input logic [4:0] sa, input logic [31:0] rs,
                                input logic [31:0] rt, output logic [3:0] ctrl,
                                output logic ill, output logic sel,
                                output logic [31:0] res, output int lat);
    int n;
    logic [31:0] ones;
    ones = '1;
    ctrl = 4'd0; ill = 1'b0; sel = 1'b0; res = 32'd0; n = 0;
    case (op)
      3'd0, 3'd4, 3'd7: ctrl = 4'd2;
      3'd1: ctrl = 4'd6;
      3'd5: ctrl = 4'd7;
      3'd6: ctrl = 4'd1;
      3'd3: ill = 1'b1;
      default: case (fn)
        6'h20: ctrl = 4'd2;
        6'h22: ctrl = 4'd6;
        6'h24: ctrl = 4'd0;
        6'h25: ctrl = 4'd1;
        6'h2a: ctrl = 4'd7;
        6'h00, 6'h02, 6'h03: begin sel = 1'b1; n = int'(sa); end
        6'h04, 6'h06, 6'h07: begin sel = 1'b1; n = int'(rs % 32); end
        default: ill = 1'b1;
      endcase
    endcase
    if (sel) begin
      ctrl = 4'hF;
      if (fn[1:0] == 2'b00)      res = rt << n;
      else if (fn[1:0] == 2'b10) res = rt >> n;
      else                       res = (rt >> n) | (rt[31] ? ~(ones >> n) : 32'd0);
    end
`ifdef ALU_CTRL_BARREL_EN
    lat = 1;
`else
    lat = (sel && n != 0) ? n + 1 : 1;
`endif
  endfunction

  // Issues one request and reports observations; checks live in the callers.
  task automatic run_req(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sa,
                         input logic [31:0] rs, input logic [31:0] rt, input int poke,
                         output int lat, output logic [3:0] ctrl, output logic ill,
                         output logic sel, output logic [31:0] res,
                         output int busy_bad, output bit after_ok);
    int w;
    bit got;
    w = 0;
    while (ready_o !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
    ALUOp_i = op; funct_i = fn; shamt_i = sa; rs_i = rs; rt_i = rt; valid_i = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after accept: results must come from sampled values.
    valid_i = 1'b0; ALUOp_i = 3'($urandom); funct_i = 6'($urandom);
    shamt_i = 5'($urandom); rs_i = $urandom; rt_i = $urandom;
    lat = 1; got = 1'b0; busy_bad = 0;
    while (!got && lat <= 40) begin
      valid_i = (poke == lat);
      if (valid_o === 1'b1) got = 1'b1;
      else begin
        if (ready_o !== 1'b0) busy_bad++;
        @(posedge clk); #1; lat++;
      end
    end
    valid_i = 1'b0;
    if (!got) lat = 0;
    if (got && ready_o !== 1'b0) busy_bad++;
    ctrl = ALUCtrl_o; ill = illegal_o; sel = sel_shift_o; res = shift_res_o;
    @(posedge clk); #1;
    after_ok = (valid_o === 1'b0) && (ready_o === 1'b1) && (ALUCtrl_o === ctrl) &&
               (illegal_o === ill) && (sel_shift_o === sel) && (shift_res_o === res);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_i = 1'b0; ALUOp_i = '0; funct_i = '0; shamt_i = '0;
    rs_i = '0; rt_i = '0;
    repeat (3) begin @(posedge clk); #1; end
    n_tests++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_hs: ready=%b valid=%b expected 1 0", ready_o, valid_o); end
    n_tests++; if (ALUCtrl_o !== 4'd0 || shift_res_o !== 32'd0) begin n_fail++;
      $display("FAIL reset_data: ctrl=%h res=%h expected 0 0", ALUCtrl_o, shift_res_o); end
    n_tests++; if (sel_shift_o !== 1'b0 || illegal_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_flags: sel=%b ill=%b expected 0 0", sel_shift_o, illegal_o); end
    rst_i = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_release: ready=%b valid=%b expected 1 0", ready_o, valid_o); end
  endtask

  task automatic test_sub();
    int lat, bb; logic [3:0] c; logic il, sl; logic [31:0] r; bit aok;
    run_req(3'b010, 6'h22, 5'd0, 32'd0, 32'd0, 0, lat, c, il, sl, r, bb, aok);
    n_tests++; if (lat !== 1 || c !== 4'b0110 || sl !== 1'b0 || il !== 1'b0) begin n_fail++;
      $display("FAIL sub: lat=%0d ctrl=%b sel=%b ill=%b expected 1 0110 0 0", lat, c, sl, il); end
    n_tests++; if (!aok || bb != 0) begin n_fail++;
      $display("FAIL sub_handshake: after_ok=%0d busy_bad=%0d expected 1 0", aok, bb); end
  endtask

  task automatic test_sra();
    int lat, bb, el; logic [3:0] c, ec; logic il, sl, ei, es; logic [31:0] r, er; bit aok;
    model(3'b010, 6'h03, 5'd4, 32'd0, 32'h8000_0010, ec, ei, es, er, el);
    run_req(3'b010, 6'h03, 5'd4, 32'h0000_001F, 32'h8000_0010, 0, lat, c, il, sl, r, bb, aok);
    n_tests++; if (r !== 32'hF800_0001 || c !== 4'b1111 || sl !== 1'b1) begin n_fail++;
      $display("FAIL sra_result: res=%h ctrl=%b sel=%b expected f8000001 1111 1", r, c, sl); end
    n_tests++; if (lat !== el || bb != 0) begin n_fail++;
      $display("FAIL sra_latency: lat=%0d busy_bad=%0d expected %0d 0", lat, bb, el); end
  endtask

  task automatic test_srlv_zero();
    int lat, bb; logic [3:0] c; logic il, sl; logic [31:0] r; bit aok;
    run_req(3'b010, 6'h06, 5'd9, 32'hFFFF_FFE0, 32'h1234_5678, 0, lat, c, il, sl, r, bb, aok);
    n_tests++; if (lat !== 1 || r !== 32'h1234_5678 || sl !== 1'b1) begin n_fail++;
      $display("FAIL srlv_zero: lat=%0d res=%h sel=%b expected 1 12345678 1", lat, r, sl); end
  endtask

  task automatic test_sll_ignore();
    int lat, bb, el; logic [3:0] c, ec; logic il, sl, ei, es; logic [31:0] r, er; bit aok;
    model(3'b010, 6'h00, 5'd31, 32'd0, 32'd1, ec, ei, es, er, el);
    run_req(3'b010, 6'h00, 5'd31, 32'd0, 32'd1, 10, lat, c, il, sl, r, bb, aok);
    n_tests++; if (lat !== el || r !== 32'h8000_0000) begin n_fail++;
      $display("FAIL sll31: lat=%0d res=%h expected %0d 80000000", lat, r, el); end
    n_tests++; if (!aok || bb != 0) begin n_fail++;
      $display("FAIL sll31_ignore: after_ok=%0d busy_bad=%0d expected 1 0", aok, bb); end
  endtask

  task automatic test_illegal();
    int lat, bb; logic [3:0] c; logic il, sl; logic [31:0] r; bit aok;
    run_req(3'b010, 6'h18, 5'd0, 32'd0, 32'd0, 0, lat, c, il, sl, r, bb, aok);
    n_tests++; if (lat !== 1 || c !== 4'b0000 || il !== 1'b1 || sl !== 1'b0) begin n_fail++;
      $display("FAIL illegal_funct: lat=%0d ctrl=%b ill=%b sel=%b expected 1 0000 1 0", lat, c, il, sl); end
    run_req(3'b011, 6'h20, 5'd0, 32'd0, 32'd0, 0, lat, c, il, sl, r, bb, aok);
    n_tests++; if (lat !== 1 || c !== 4'b0000 || il !== 1'b1 || sl !== 1'b0) begin n_fail++;
      $display("FAIL illegal_aluop: lat=%0d ctrl=%b ill=%b sel=%b expected 1 0000 1 0", lat, c, il, sl); end
  endtask

  task automatic test_back_to_back();
    bit ev;
    ALUOp_i = 3'b010; funct_i = 6'h20; valid_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      ev = (k % 2 == 1);
      n_tests++; if (valid_o !== ev || ready_o !== !ev) begin n_fail++;
        $display("FAIL b2b_cycle%0d: valid=%b ready=%b expected %b %b", k, valid_o, ready_o, ev, !ev); end
    end
    valid_i = 1'b0;
    n_tests++; if (ALUCtrl_o !== 4'b0010) begin n_fail++;
      $display("FAIL b2b_ctrl: ctrl=%b expected 0010", ALUCtrl_o); end
  endtask

  task automatic test_reset_mid_shift();
    int lat, bb, stray; logic [3:0] c; logic il, sl; logic [31:0] r; bit aok;
    run_req(3'b110, 6'h00, 5'd0, 32'd0, 32'd0, 0, lat, c, il, sl, r, bb, aok);
    ALUOp_i = 3'b010; funct_i = 6'h00; shamt_i = 5'd20; rt_i = $urandom | 32'd1;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
`ifdef ALU_CTRL_BARREL_EN
    n_tests++; if (valid_o !== 1'b1) begin n_fail++;
      $display("FAIL barrel_lat: valid=%b at T+1 expected 1", valid_o); end
`endif
    repeat (7) begin @(posedge clk); #1; end
`ifndef ALU_CTRL_BARREL_EN
    n_tests++; if (ready_o !== 1'b0 || valid_o !== 1'b0) begin n_fail++;
      $display("FAIL midshift_busy: ready=%b valid=%b expected 0 0", ready_o, valid_o); end
`endif
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    n_tests++; if (ready_o !== 1'b1 || valid_o !== 1'b0 || ALUCtrl_o !== 4'd0 ||
                   shift_res_o !== 32'd0 || sel_shift_o !== 1'b0 || illegal_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midshift_reset: ready=%b valid=%b ctrl=%b res=%h sel=%b ill=%b expected 1 0 0 0 0 0",
               ready_o, valid_o, ALUCtrl_o, shift_res_o, sel_shift_o, illegal_o); end
    stray = 0;
    repeat (30) begin @(posedge clk); #1; if (valid_o !== 1'b0) stray++; end
    n_tests++; if (stray != 0) begin n_fail++;
      $display("FAIL midshift_abort: stray valid cycles=%0d expected 0", stray); end
  endtask

  task automatic test_random();
    int lat, bb, el; logic [3:0] c, ec; logic il, sl, ei, es; logic [31:0] r, er; bit aok;
    logic [2:0] op; logic [5:0] fn; logic [4:0] sa; logic [31:0] rs, rt;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'($urandom_range(0, 7));
      fn = fn_tab[$urandom_range(0, 12)];
      sa = 5'($urandom); rs = $urandom; rt = $urandom;
      model(op, fn, sa, rs, rt, ec, ei, es, er, el);
      run_req(op, fn, sa, rs, rt, 0, lat, c, il, sl, r, bb, aok);
      n_tests++; if (c !== ec || il !== ei || sl !== es) begin n_fail++;
        $display("FAIL rand%0d_decode: op=%b fn=%h ctrl=%b ill=%b sel=%b expected %b %b %b",
                 i, op, fn, c, il, sl, ec, ei, es); end
      n_tests++; if (lat !== el || bb != 0 || !aok) begin n_fail++;
        $display("FAIL rand%0d_timing: lat=%0d busy_bad=%0d after_ok=%0d expected %0d 0 1",
                 i, lat, bb, aok, el); end
      if (es) begin
        n_tests++; if (r !== er) begin n_fail++;
          $display("FAIL rand%0d_shift: fn=%h rt=%h res=%h expected %h", i, fn, rt, r, er); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_sra();
    test_srlv_zero();
    test_sll_ignore();
    test_illegal();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
